// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR datapath and its result serializer.
//   WORD_W      : width of the LFSR result bus and of each serialized word
//   OVF_W       : width of the saturating dropped-word counter
//   ser_state_t : serializer FSM states
package lfsr_pkg;

    localparam int WORD_W = 32;
    localparam int OVF_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO holding result words waiting to be serialized.
// Read data is presented combinationally from the head entry.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   push     : write din (ignored when full unless a pop happens the same cycle)
//   pop      : remove the head entry (ignored when empty)
//   din      : word to write
//   dout     : head entry, valid while !empty
//   full     : level == DEPTH
//   empty    : level == 0
//   level    : current occupancy, 0..DEPTH
module result_fifo #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WORD_W-1:0]        din,
    output logic [WORD_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_en;
    logic              rd_en;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    assign dout = mem[rd_ptr];

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage has no reset; stale entries are never read because the
    // pointers and level are reset, and this keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/result_serializer.sv
// Detects each new value on the LFSR result bus, buffers it in a small FIFO
// and streams every buffered word MSB-first over a per-bit valid/ready link.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   result       : LFSR datapath output, sampled every cycle
//   sready       : sink accepts the current bit
//   sdata        : current serial bit
//   svalid       : sdata is valid
//   sfirst       : high with the MSB of each word
//   fifo_level   : FIFO occupancy (registered, reflects the previous edge)
//   overflow_cnt : number of dropped words, saturating at 255
module result_serializer
    import lfsr_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WORD_W = lfsr_pkg::WORD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WORD_W-1:0]        result,
    input  logic                     sready,
    output logic                     sdata,
    output logic                     svalid,
    output logic                     sfirst,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [OVF_W-1:0]         overflow_cnt
);

    localparam int BW = $clog2(WORD_W);
    localparam logic [BW-1:0] LAST_IDX = BW'(WORD_W - 1);

    ser_state_t        state;
    ser_state_t        state_next;
    logic [WORD_W-1:0] prev_result;
    logic [WORD_W-1:0] shreg;
    logic [BW-1:0]     bitcnt;
    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              load;
    logic              shift;
    logic              drop;

    // Any change of the bus is a new word; the first nonzero value after
    // reset counts as a change because prev_result resets to 0.
    assign push = (result != prev_result);
    assign drop = push && fifo_full && !pop;

    result_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (result),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // NOTE: every signal driven here gets a default first so that no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (sready) begin
                    if (bitcnt == '0) begin
                        // Reload on the final bit so consecutive words have no bubble.
                        if (!fifo_empty) begin
                            pop  = 1'b1;
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            prev_result  <= '0;
            shreg        <= '0;
            bitcnt       <= '0;
            overflow_cnt <= '0;
        end else begin
            state       <= state_next;
            prev_result <= result;
            if (load) begin
                shreg  <= fifo_dout;
                bitcnt <= LAST_IDX;
            end else if (shift) begin
                shreg  <= {shreg[WORD_W-2:0], 1'b0};
                bitcnt <= bitcnt - BW'(1);
            end
            if (drop && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + OVF_W'(1);
            end
        end
    end

    // Outputs depend only on registers, so they hold while sready is low.
    assign svalid = (state == SHIFT);
    assign sdata  = svalid && shreg[WORD_W-1];
    assign sfirst = svalid && (bitcnt == LAST_IDX);

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer. A queue-based reference model
// tracks buffered words, the word on the wire and the drop count; every
// cycle the DUT outputs are compared against it, plus directed checks.
module tb_result_serializer;

    localparam int DEPTH = 4;
    localparam int W     = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  result;
    logic          sready;
    logic          sdata;
    logic          svalid;
    logic          sfirst;
    logic [2:0]    fifo_level;
    logic [7:0]    overflow_cnt;

    always #5 clk = ~clk;

    result_serializer #(.DEPTH(DEPTH), .WORD_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .result       (result),
        .sready       (sready),
        .sdata        (sdata),
        .svalid       (svalid),
        .sfirst       (sfirst),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] m_prev;
    logic [W-1:0] m_q[$];
    bit           m_busy;
    logic [W-1:0] m_word;
    int           m_idx;
    int           m_ovf;

    // Outputs observed in the most recent cycle
    logic o_valid, o_data, o_first;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = '0;
        m_q.delete();
        m_busy = 1'b0;
        m_word = '0;
        m_idx  = 0;
        m_ovf  = 0;
    endtask

    // One clock edge of behaviour: bit handshake, word hand-off, new-word capture.
    task automatic model_edge(input logic [W-1:0] res, input logic rdy);
        bit hs, fin, take;
        hs   = m_busy && rdy;
        fin  = hs && (m_idx == 0);
        take = (!m_busy || fin) && (m_q.size() > 0);
        if (hs && m_idx > 0) m_idx--;
        if (take) begin
            m_word = m_q.pop_front();
            m_idx  = W - 1;
            m_busy = 1'b1;
        end else if (fin) begin
            m_busy = 1'b0;
        end
        if (res != m_prev) begin
            if (m_q.size() < DEPTH) m_q.push_back(res);
            else if (m_ovf < 255) m_ovf++;
        end
        m_prev = res;
    endtask

    // Observe and check outputs, then drive inputs for the coming edge.
    task automatic cyc(input logic [W-1:0] res, input logic rdy, input logic rs);
        logic e_data;
        @(negedge clk);
        o_valid = svalid;
        o_data  = sdata;
        o_first = sfirst;
        e_data  = m_busy ? m_word[m_idx] : 1'b0;
        check("svalid", svalid, m_busy);
        check("sdata", sdata, e_data);
        check("sfirst", sfirst, m_busy && (m_idx == W - 1));
        check("fifo_level", fifo_level, m_q.size());
        check("overflow_cnt", overflow_cnt, m_ovf);
        result = res;
        sready = rdy;
        rst    = rs;
        if (rs) model_reset();
        else    model_edge(res, rdy);
    endtask

    initial begin
        logic [W-1:0] got;
        logic [W-1:0] words[$];
        int           nfirst, nvalid, hs, s, nb;
        logic         pv, pd, pf, prdy;
        logic         v[80], f[80], d[80];
        logic [W-1:0] cur;

        rst    = 1'b1;
        result = '0;
        sready = 1'b0;
        model_reset();
        cyc('0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b0);
        check("reset_svalid", o_valid, 1'b0);

        // Single word: 2-cycle latency, MSB-first, sfirst on bit 31 only
        cyc(32'hA5A5_0001, 1'b1, 1'b0);
        cyc(32'hA5A5_0001, 1'b1, 1'b0);
        check("latency_not_yet", o_valid, 1'b0);
        got = '0; nfirst = 0; nvalid = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(32'hA5A5_0001, 1'b1, 1'b0);
            got = {got[W-2:0], o_data};
            nfirst += int'(o_first);
            nvalid += int'(o_valid);
        end
        check("single_word", got, 32'hA5A5_0001);
        check("single_nvalid", nvalid, 32);
        check("single_nfirst", nfirst, 1);
        cyc(32'hA5A5_0001, 1'b1, 1'b0);
        check("single_idle", o_valid, 1'b0);
        check("single_ovf", overflow_cnt, 8'd0);

        // Backpressure: sready toggles every cycle
        got = '0; hs = 0; pv = 1'b0; pd = 1'b0; pf = 1'b0; prdy = 1'b1;
        cyc(32'h8000_0001, 1'b1, 1'b0);
        for (int i = 0; i < 200 && hs < 32; i++) begin
            logic r;
            r = 1'(i % 2);
            cyc(32'h8000_0001, r, 1'b0);
            if (pv && !prdy) check("bp_stable", {o_valid, o_first, o_data}, {1'b1, pf, pd});
            if (o_valid && r) begin
                got = {got[W-2:0], o_data};
                hs++;
            end
            pv = o_valid; pd = o_data; pf = o_first; prdy = r;
        end
        check("bp_word", got, 32'h8000_0001);
        check("bp_handshakes", hs, 32);
        cyc(32'h8000_0001, 1'b1, 1'b0);
        check("bp_idle", o_valid, 1'b0);

        // Back-to-back words with no idle cycle between them
        cyc(32'h1, 1'b1, 1'b0);
        for (int i = 0; i < 80; i++) begin
            cyc(32'h2, 1'b1, 1'b0);
            v[i] = o_valid; f[i] = o_first; d[i] = o_data;
        end
        s = 0;
        for (int i = 15; i >= 0; i--) if (v[i]) s = i;
        nvalid = 0; got = '0;
        for (int i = 0; i < 64; i++) nvalid += int'(v[s + i]);
        for (int i = 32; i < 64; i++) got = {got[W-2:0], d[s + i]};
        check("b2b_no_gap", nvalid, 64);
        check("b2b_lsb_of_1", d[s + 31], 1'b1);
        check("b2b_sfirst_2", f[s + 32], 1'b1);
        check("b2b_word2", got, 32'h2);
        check("b2b_idle_after", v[s + 64], 1'b0);

        // Overflow: 6 changes with the sink stalled
        for (int i = 0; i < 6; i++) cyc(32'h100 + W'(i), 1'b0, 1'b0);
        cyc(32'h105, 1'b0, 1'b0);
        check("ovf_level", fifo_level, 3'd4);
        check("ovf_cnt", overflow_cnt, 8'd1);
        words.delete(); got = '0; nb = 0;
        for (int i = 0; i < 5 * 32 + 20; i++) begin
            cyc(32'h105, 1'b1, 1'b0);
            if (o_valid) begin
                got = {got[W-2:0], o_data};
                nb++;
                if (nb % 32 == 0) words.push_back(got);
            end
        end
        check("ovf_nwords", words.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < words.size()) check("ovf_order", words[i], 32'h100 + W'(i));
        end

        // Saturation: 300 changes with the sink stalled, then hold
        for (int i = 0; i < 300; i++) cyc(32'h1000 + W'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(32'h1000 + W'(299), 1'b0, 1'b0);
        check("sat_cnt", overflow_cnt, 8'd255);
        check("sat_hold_level", fifo_level, 3'd4);
        for (int i = 0; i < 5 * 32 + 10; i++) cyc(32'h1000 + W'(299), 1'b1, 1'b0);
        check("sat_drained", fifo_level, 3'd0);
        check("sat_cnt_kept", overflow_cnt, 8'd255);

        // Reset in the middle of a word
        cyc(32'h1111_1111, 1'b1, 1'b0);
        cyc(32'hDEAD_BEEF, 1'b1, 1'b0);
        hs = 0;
        for (int i = 0; i < 50 && hs < 10; i++) begin
            cyc(32'hDEAD_BEEF, 1'b1, 1'b0);
            if (o_valid) hs++;
        end
        cyc(32'hDEAD_BEEF, 1'b1, 1'b1);
        cyc(32'hDEAD_BEEF, 1'b1, 1'b0);
        check("rst_svalid", o_valid, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_ovf", overflow_cnt, 8'd0);
        got = '0; nb = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(32'hDEAD_BEEF, 1'b1, 1'b0);
            if (o_valid) begin
                got = {got[W-2:0], o_data};
                nb++;
            end
        end
        check("rst_repush_bits", nb, 32);
        check("rst_repush_word", got, 32'hDEAD_BEEF);

        // Random traffic at several change rates and sink duty cycles
        cur = 32'hDEAD_BEEF;
        for (int blk = 0; blk < 6; blk++) begin
            int rate;
            rate = (blk % 3 == 0) ? 48 : ((blk % 3 == 1) ? 20 : 4);
            for (int i = 0; i < 500; i++) begin
                logic r, rs;
                if ($urandom_range(rate - 1) == 0) cur = $urandom;
                r  = ($urandom_range(3) != 0);
                rs = ($urandom_range(999) == 0);
                cyc(cur, r, rs);
            end
        end
        for (int i = 0; i < 6 * 32; i++) cyc(cur, 1'b1, 1'b0);
        cyc(cur, 1'b1, 1'b0);
        check("final_idle", o_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
